// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Constants and FSM state encoding shared by the UART receive
//               path (uart_rx_x4) and the uart_buffer transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Samples per bit period supplied by the UART clock generator tick.
    localparam int OVERSAMPLE        = 4;
    // Tick after start detection that lands near the middle of the start bit.
    localparam int START_SAMPLE_TICK = 2;
    // Idle (mark) level of the serial line.
    localparam logic LINE_IDLE       = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_x4_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_x4_if
// Description : Line-side inputs and received-data outputs of the 4x
//               oversampling UART receiver. The slave modport is the receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_x4_if #(
    parameter int DATA_BITS = 8
);
    logic                 baud_x4;
    logic                 serial_rx;
    logic [DATA_BITS-1:0] data;
    logic                 data_strobe;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    modport master (
        output baud_x4,
        output serial_rx,
        input  data,
        input  data_strobe,
        input  frame_err,
        input  parity_err,
        input  busy
    );

    modport slave (
        input  baud_x4,
        input  serial_rx,
        output data,
        output data_strobe,
        output frame_err,
        output parity_err,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_x4_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for a single asynchronous input with a
//               selectable reset value. Also used for the pps input.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_q
);
    logic r_meta;
    logic r_sync;

    // Two back-to-back flops; the first may go metastable, the second settles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_x4.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_x4
// Description : UART receiver (start, DATA_BITS data LSB first, optional
//               parity, one stop) sampled with a 4x-baud tick. Emits a
//               one-clk data_strobe per good byte, frame_err on a low stop
//               bit and parity_err on a parity mismatch.
//               Build option: define UART_RX_PARITY_EN to add a parity bit
//               checked with sense PARITY_ODD (0 = even, 1 = odd).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_x4
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  wire logic   clk,
    input  wire logic   reset,
    uart_rx_x4_if.slave bus
);
    localparam logic [1:0] c_tick_last  = 2'(OVERSAMPLE - 1);
    localparam logic [1:0] c_start_last = 2'(START_SAMPLE_TICK - 1);
    localparam logic [2:0] c_bit_last   = 3'(DATA_BITS - 1);
    localparam logic       c_par_sense  = 1'(PARITY_ODD);

    logic                 w_rx_s;
    uart_state_e          r_state,  w_state_nxt;
    logic [1:0]           r_tcnt,   w_tcnt_nxt;
    logic [2:0]           r_bcnt,   w_bcnt_nxt;
    logic [DATA_BITS-1:0] r_shreg,  w_shreg_nxt;
    logic [DATA_BITS-1:0] r_data,   w_data_nxt;
    logic                 r_strobe, w_strobe_nxt;
    logic                 r_ferr,   w_ferr_nxt;
    logic                 w_tcnt_wrap;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bad, w_par_bad_nxt;
    logic                 r_perr,    w_perr_nxt;
`endif

    sync_2ff #(
        .RESET_VAL (LINE_IDLE)
    ) u_sync_rx (
        .clk (clk),
        .rst (reset),
        .i_d (bus.serial_rx),
        .o_q (w_rx_s)
    );

    // A full bit period has elapsed since the previous sample point.
    assign w_tcnt_wrap = (r_tcnt == c_tick_last);

    // Next-state and pulse decode; everything holds between baud ticks.
    always_comb begin
        w_state_nxt  = r_state;
        w_tcnt_nxt   = r_tcnt;
        w_bcnt_nxt   = r_bcnt;
        w_shreg_nxt  = r_shreg;
        w_data_nxt   = r_data;
        w_strobe_nxt = 1'b0;
        w_ferr_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nxt = r_par_bad;
        w_perr_nxt    = 1'b0;
`endif
        if (bus.baud_x4) begin
            case (r_state)
                IDLE: begin
                    if (w_rx_s != LINE_IDLE) begin
                        w_state_nxt = START;
                        w_tcnt_nxt  = '0;
                    end
                end
                START: begin
                    // Re-check the line near mid start bit to reject glitches.
                    if (r_tcnt == c_start_last) begin
                        if (w_rx_s == LINE_IDLE) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = DATA;
                            w_tcnt_nxt  = '0;
                            w_bcnt_nxt  = '0;
                        end
                    end else begin
                        w_tcnt_nxt = r_tcnt + 2'd1;
                    end
                end
                DATA: begin
                    if (w_tcnt_wrap) begin
                        w_tcnt_nxt  = '0;
                        w_shreg_nxt = {w_rx_s, r_shreg[DATA_BITS-1:1]};
                        w_bcnt_nxt  = r_bcnt + 3'd1;
                        if (r_bcnt == c_bit_last) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = PARITY;
`else
                            w_state_nxt = STOP;
`endif
                        end
                    end else begin
                        w_tcnt_nxt = r_tcnt + 2'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_tcnt_wrap) begin
                        w_tcnt_nxt    = '0;
                        w_par_bad_nxt = ((^r_shreg) ^ w_rx_s) != c_par_sense;
                        w_state_nxt   = STOP;
                    end else begin
                        w_tcnt_nxt = r_tcnt + 2'd1;
                    end
                end
`endif
                STOP: begin
                    if (w_tcnt_wrap) begin
                        w_tcnt_nxt = '0;
                        if (w_rx_s == LINE_IDLE) begin
                            w_state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                            if (r_par_bad) begin
                                w_perr_nxt = 1'b1;
                            end else begin
                                w_data_nxt   = r_shreg;
                                w_strobe_nxt = 1'b1;
                            end
`else
                            w_data_nxt   = r_shreg;
                            w_strobe_nxt = 1'b1;
`endif
                        end else begin
                            // A low stop bit outranks any parity result.
                            w_ferr_nxt  = 1'b1;
                            w_state_nxt = WAIT_IDLE;
                        end
                    end else begin
                        w_tcnt_nxt = r_tcnt + 2'd1;
                    end
                end
                WAIT_IDLE: begin
                    // Break or stuck-low line: wait for mark before re-arming.
                    if (w_rx_s == LINE_IDLE) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, counters, shift register and registered output pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_tcnt   <= '0;
            r_bcnt   <= '0;
            r_shreg  <= '0;
            r_data   <= '0;
            r_strobe <= 1'b0;
            r_ferr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_tcnt   <= w_tcnt_nxt;
            r_bcnt   <= w_bcnt_nxt;
            r_shreg  <= w_shreg_nxt;
            r_data   <= w_data_nxt;
            r_strobe <= w_strobe_nxt;
            r_ferr   <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= w_par_bad_nxt;
            r_perr    <= w_perr_nxt;
`endif
        end
    end

    assign bus.data        = r_data;
    assign bus.data_strobe = r_strobe;
    assign bus.frame_err   = r_ferr;
    assign bus.busy        = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err  = r_perr;
`else
    // No parity bit in the frame; the sense setting has no effect here.
    assign bus.parity_err  = 1'b0 & c_par_sense;
`endif

endmodule
`default_nettype wire
